// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM of the 8-bit processor: sequences fetch/decode/execute/memory/write-back
// and drives every datapath enable, including SelEndReg into the MUX3_3 Controle input.
module unidade_controle_multiciclo #(
    parameter int LARG_OP  = 4,
    parameter int END_LINK = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [LARG_OP-1:0] Opcode,
    input  logic               Zero,
    input  logic               MemPronto,
    output logic               EscreveIR,
    output logic               EscrevePC,
    output logic [1:0]         SelPC,
    output logic               LeMem,
    output logic               EscreveMem,
    output logic               EscreveReg,
    output logic [1:0]         SelEndReg,
    output logic               SelDadoReg,
    output logic [2:0]         OpULA,
    output logic               Parado,
    output logic               Invalido
);

    localparam logic [2:0] BUSCA      = 3'd0;
    localparam logic [2:0] DECODIFICA = 3'd1;
    localparam logic [2:0] EXECUTA    = 3'd2;
    localparam logic [2:0] MEMORIA    = 3'd3;
    localparam logic [2:0] ESCRITA    = 3'd4;
    localparam logic [2:0] PARADO     = 3'd5;

    localparam logic [LARG_OP-1:0] OP_ADD  = LARG_OP'(4'b0000);
    localparam logic [LARG_OP-1:0] OP_SUB  = LARG_OP'(4'b0001);
    localparam logic [LARG_OP-1:0] OP_AND  = LARG_OP'(4'b0010);
    localparam logic [LARG_OP-1:0] OP_OR   = LARG_OP'(4'b0011);
    localparam logic [LARG_OP-1:0] OP_ADDI = LARG_OP'(4'b0100);
    localparam logic [LARG_OP-1:0] OP_LW   = LARG_OP'(4'b0101);
    localparam logic [LARG_OP-1:0] OP_SW   = LARG_OP'(4'b0110);
    localparam logic [LARG_OP-1:0] OP_BEQ  = LARG_OP'(4'b0111);
    localparam logic [LARG_OP-1:0] OP_JAL  = LARG_OP'(4'b1000);
    localparam logic [LARG_OP-1:0] OP_HLT  = LARG_OP'(4'b1111);

    logic [2:0]         state_q,  state_d;
    logic [LARG_OP-1:0] opcode_q, opcode_d;

    function automatic logic op_valido(input logic [LARG_OP-1:0] op);
        logic v;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
            OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_HLT: v = 1'b1;
            default:                              v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic op_tipo_r(input logic [LARG_OP-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state and opcode-latch logic.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            BUSCA: begin
                if (MemPronto) begin
                    state_d = DECODIFICA;
                end else begin
                    state_d = BUSCA;
                end
            end
            DECODIFICA: begin
                opcode_d = Opcode;
                if (Opcode == OP_JAL) begin
                    state_d = ESCRITA;
                end else if (Opcode == OP_HLT) begin
                    state_d = PARADO;
                end else if (op_valido(Opcode)) begin
                    state_d = EXECUTA;
                end else begin
                    state_d = BUSCA;
                end
            end
            EXECUTA: begin
                if (opcode_q == OP_BEQ) begin
                    state_d = BUSCA;
                end else if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
                    state_d = MEMORIA;
                end else begin
                    state_d = ESCRITA;
                end
            end
            MEMORIA: begin
                if (!MemPronto) begin
                    state_d = MEMORIA;
                end else if (opcode_q == OP_LW) begin
                    state_d = ESCRITA;
                end else begin
                    state_d = BUSCA;
                end
            end
            ESCRITA: state_d = BUSCA;
            PARADO:  state_d = PARADO;
            default: state_d = BUSCA;
        endcase
    end

    // State and latched opcode registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= BUSCA;
            opcode_q <= OP_ADD;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Output decode from state and latched opcode; handshake strobes are qualified by
    // MemPronto/Zero, and everything is forced low while Reset is held.
    always_comb begin
        EscreveIR  = 1'b0;
        EscrevePC  = 1'b0;
        SelPC      = 2'b00;
        LeMem      = 1'b0;
        EscreveMem = 1'b0;
        EscreveReg = 1'b0;
        SelEndReg  = 2'b00;
        SelDadoReg = 1'b0;
        OpULA      = 3'b000;
        Parado     = 1'b0;
        Invalido   = 1'b0;
        if (Reset) begin
            case (state_q)
                BUSCA: begin
                    LeMem     = 1'b1;
                    EscreveIR = MemPronto;
                    EscrevePC = MemPronto;
                end
                DECODIFICA: Invalido = ~op_valido(Opcode);
                EXECUTA: begin
                    case (opcode_q)
                        OP_SUB, OP_BEQ: OpULA = 3'b001;
                        OP_AND:         OpULA = 3'b010;
                        OP_OR:          OpULA = 3'b011;
                        default:        OpULA = 3'b000;
                    endcase
                    if ((opcode_q == OP_BEQ) && Zero) begin
                        EscrevePC = 1'b1;
                        SelPC     = 2'b01;
                    end else begin
                        EscrevePC = 1'b0;
                    end
                end
                MEMORIA: begin
                    LeMem      = (opcode_q == OP_LW);
                    EscreveMem = (opcode_q == OP_SW);
                end
                ESCRITA: begin
                    EscreveReg = 1'b1;
                    SelDadoReg = (opcode_q == OP_LW);
                    if (opcode_q == OP_JAL) begin
                        SelEndReg = 2'(END_LINK);
                        EscrevePC = 1'b1;
                        SelPC     = 2'b10;
                    end else if (op_tipo_r(opcode_q)) begin
                        SelEndReg = 2'b01;
                    end else begin
                        SelEndReg = 2'b00;
                    end
                end
                PARADO:  Parado = 1'b1;
                default: Parado = 1'b0;
            endcase
        end else begin
            Parado = 1'b0;
        end
    end

endmodule
